tmr: RTL and testbench

- Programmable interval timer on the I/O bus, selected by the bus controller at 0x30000000 (tmr_en).
- Free-running prescaler produces ticks; a 32-bit down-counter reloads from a software-written divisor on each tick.
- Counter expiry sets a sticky flag and optionally raises an interrupt to the CPU.
- Two word registers, selected by addr2; every access takes exactly one wait state.

---
 rtl/tmr_pkg.sv | 23 ++
 rtl/tmr_prescaler.sv | 28 ++
 rtl/tmr.sv | 101 ++++++++++
 tb/tb_tmr.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the interval timer: register selects, CTRL bit layout
// and the I/O base decode value.
package tmr_pkg;

    typedef enum logic {
        TMR_REG_CTRL = 1'b0,
        TMR_REG_DIV  = 1'b1
    } tmr_reg_e;

    localparam int TMR_CTRL_EXP = 0;
    localparam int TMR_CTRL_IEN = 1;

    localparam logic [7:0] TMR_IO_BASE = 8'h00;

    function automatic logic [31:0] tmr_ctrl_word(input logic ien, input logic exp_flag);
        logic [31:0] w;
        w = 32'h0;
        w[TMR_CTRL_IEN] = ien;
        w[TMR_CTRL_EXP] = exp_flag;
        return w;
    endfunction

endpackage

// File: rtl/tmr_prescaler.sv
// Free-running prescaler: one-cycle tick every PRE_DIV clocks, phase reset by restart.
module tmr_prescaler #(
    parameter int PRE_DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(PRE_DIV - 1);

    logic [W-1:0] pre_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (restart || pre_cnt == LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == LAST);

endmodule

// File: rtl/tmr.sv
// Programmable interval timer: prescaled 32-bit reloading down-counter with a
// sticky expiry flag, interrupt enable and a one-wait-state bus handshake.
module tmr
    import tmr_pkg::*;
#(
    parameter int          PRE_DIV   = 50,
    parameter logic [31:0] DIV_RESET = 32'h0000C350
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        wr,
    input  logic        addr2,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        wt,
    output logic        irq
);

    logic        ack;
    logic        exp_flag;
    logic        ien;
    logic [31:0] divisor;
    logic [31:0] counter;
    logic        tick;
    logic        wr_commit;
    logic        ctrl_wr;
    logic        div_wr;
    logic        expire;

    assign wr_commit = en & ack & wr;
    assign ctrl_wr   = wr_commit & (tmr_reg_e'(addr2) == TMR_REG_CTRL);
    assign div_wr    = wr_commit & (tmr_reg_e'(addr2) == TMR_REG_DIV);

    // A DIV write in a tick cycle wins, so it also suppresses that cycle's expiry.
    assign expire = tick & ~div_wr & (divisor != 32'h0) & (counter == 32'h1);

    tmr_prescaler #(.PRE_DIV(PRE_DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (div_wr),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack <= 1'b0;
        end else begin
            ack <= en & ~ack;
        end
    end

    assign wt = en & ~ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divisor <= DIV_RESET;
            counter <= DIV_RESET;
        end else if (div_wr) begin
            divisor <= data_in;
            counter <= data_in;
        end else if (tick && divisor != 32'h0) begin
            if (counter == 32'h1 || counter == 32'h0) begin
                counter <= divisor;
            end else begin
                counter <= counter - 32'h1;
            end
        end
    end

    // Expiry outranks a software clear so an interrupt is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_flag <= 1'b0;
            ien      <= 1'b0;
        end else begin
            if (expire) begin
                exp_flag <= 1'b1;
            end else if (ctrl_wr) begin
                exp_flag <= data_in[TMR_CTRL_EXP];
            end
            if (ctrl_wr) begin
                ien <= data_in[TMR_CTRL_IEN];
            end
        end
    end

    always_comb begin
        data_out = 32'h0;
        if (en) begin
            case (tmr_reg_e'(addr2))
                TMR_REG_CTRL: data_out = tmr_ctrl_word(ien, exp_flag);
                TMR_REG_DIV:  data_out = divisor;
                default:      data_out = 32'h0;
            endcase
        end
    end

    assign irq = exp_flag & ien;

endmodule

// File: tb/tb_tmr.sv
// Directed bench for tmr: one instance with PRE_DIV=1 and one with PRE_DIV=4,
// read data checked through an expected-value queue.
module tb_tmr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en    [2];
    logic        wr    [2];
    logic        addr2 [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic        wt    [2];
    logic        irq   [2];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic        stop_seen;

    always #5 clk = ~clk;

    tmr #(.PRE_DIV(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en[0]), .wr(wr[0]), .addr2(addr2[0]),
        .data_in(din[0]), .data_out(dout[0]), .wt(wt[0]), .irq(irq[0])
    );

    tmr #(.PRE_DIV(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en[1]), .wr(wr[1]), .addr2(addr2[1]),
        .data_in(din[1]), .data_out(dout[1]), .wt(wt[1]), .irq(irq[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the access completes (and a write
    // commits) on the second following edge, returning 1ns after it.
    task automatic access(input int d, input logic w, input logic a,
                          input logic [31:0] data, input string tag);
        logic [31:0] e;
        en[d] = 1'b1; wr[d] = w; addr2[d] = a; din[d] = data;
        @(negedge clk);
        check({tag, "_wt_first"}, {31'b0, wt[d]}, 32'd1);
        step();
        @(negedge clk);
        check({tag, "_wt_done"}, {31'b0, wt[d]}, 32'd0);
        if (!w) begin
            if (exp_q.size() == 0) begin
                e = 32'hx;
            end else begin
                e = exp_q.pop_front();
            end
            check(tag, dout[d], e);
        end
        step();
        en[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic bus_read(input int d, input logic a, input logic [31:0] expv, input string tag);
        exp_q.push_back(expv);
        access(d, 1'b0, a, 32'h0, tag);
    endtask

    task automatic bus_write(input int d, input logic a, input logic [31:0] data, input string tag);
        access(d, 1'b1, a, data, tag);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; wr[i] = 1'b0; addr2[i] = 1'b0; din[i] = 32'h0;
        end
        reset_n = 1'b0;
        #2;
        check("rst_wt_idle",  {31'b0, wt[0]}, 32'd0);
        check("rst_irq",      {31'b0, irq[0]}, 32'd0);
        check("rst_dout_idle", dout[0], 32'h0);
        en[0] = 1'b1;
        #1;
        check("rst_wt_follows_en", {31'b0, wt[0]}, 32'd1);
        en[0] = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();

        // reset values through the bus
        bus_read(0, 1'b0, 32'h0000_0000, "rd_ctrl_rst");
        bus_read(0, 1'b1, 32'h0000_C350, "rd_div_rst");
        check("irq_after_rst", {31'b0, irq[0]}, 32'd0);

        // period with PRE_DIV=1
        bus_write(0, 1'b0, 32'h2, "wr_ctrl_ien");
        bus_write(0, 1'b1, 32'd5, "wr_div5");
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("period1_k%0d", k), {31'b0, irq[0]}, (k == 5) ? 32'd1 : 32'd0);
        end

        // CTRL clear landing on the expiry edge loses to expiry
        step(); step(); step();
        bus_write(0, 1'b0, 32'h2, "wr_ctrl_race");
        check("race_irq_kept", {31'b0, irq[0]}, 32'd1);
        bus_write(0, 1'b0, 32'h2, "wr_ctrl_ack");
        check("ack_irq_cleared", {31'b0, irq[0]}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("period2_k%0d", k), {31'b0, irq[0]}, (k == 3) ? 32'd1 : 32'd0);
        end
        bus_read(0, 1'b0, 32'h0000_0003, "rd_ctrl_set");

        // aborted write: en drops while ack is high
        en[0] = 1'b1; wr[0] = 1'b1; addr2[0] = 1'b1; din[0] = 32'h0000_1234;
        step();
        en[0] = 1'b0; wr[0] = 1'b0;
        step();
        bus_read(0, 1'b1, 32'd5, "rd_div_abort");

        // PRE_DIV=4: stopped timer, then prescaled period
        bus_write(1, 1'b0, 32'h2, "b_wr_ctrl_ien");
        bus_write(1, 1'b1, 32'd0, "b_wr_div0");
        stop_seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (irq[1]) stop_seen = 1'b1;
        end
        check("b_stopped_no_expiry", {31'b0, stop_seen}, 32'd0);
        bus_write(1, 1'b1, 32'd3, "b_wr_div3");
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("b_period_k%0d", k), {31'b0, irq[1]}, (k == 12) ? 32'd1 : 32'd0);
        end

        // DIV write committing on a tick edge: full 12-cycle period follows
        bus_write(1, 1'b0, 32'h2, "b_wr_ctrl_ack");
        check("b_ack_irq_cleared", {31'b0, irq[1]}, 32'd0);
        bus_write(1, 1'b1, 32'd3, "b_wr_div_on_tick");
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("b_tick_wr_k%0d", k), {31'b0, irq[1]}, (k == 12) ? 32'd1 : 32'd0);
        end

        // asynchronous reset in the completion cycle of a DIV write
        en[0] = 1'b1; wr[0] = 1'b1; addr2[0] = 1'b1; din[0] = 32'h0000_DEAD;
        step();
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_wt_eq_en", {31'b0, wt[0]}, 32'd1);
        check("arst_irq", {31'b0, irq[0]}, 32'd0);
        check("arst_div_async", dout[0], 32'h0000_C350);
        en[0] = 1'b0; wr[0] = 1'b0;
        #1;
        check("arst_wt_idle", {31'b0, wt[0]}, 32'd0);
        reset_n = 1'b1;
        step();
        bus_read(0, 1'b1, 32'h0000_C350, "rd_div_after_arst");
        bus_read(0, 1'b0, 32'h0000_0000, "rd_ctrl_after_arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
